// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use and multiply stalls, multiply tracking,
// taken-branch flush sequencing, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int REG_AW    = 4,
  parameter int MUL_LAT   = 3,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_is_mul,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mul_start,
  input  logic [REG_AW-1:0] mul_rd,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              mul_busy,
  output logic              mul_done,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int MCW = $clog2(MUL_LAT + 1);
  localparam int FCW = $clog2(FLUSH_CYC + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_BAD      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [MCW-1:0]     mul_cnt_q, mul_cnt_d;
  logic [REG_AW-1:0]  mul_rd_q, mul_rd_d;
  logic [FCW-1:0]     flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               load_haz;
  logic               mul_haz;

  // Register zero is hardwired, so a write to it can never create a dependency.
  function automatic logic reg_match(input logic [REG_AW-1:0] r,
                                     input logic              valid,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt,
                                     input logic              uses_rt);
    return valid && (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  assign mul_busy    = (mul_cnt_q != '0);
  assign mul_done    = (mul_cnt_q == MCW'(1));
  assign load_haz    = ex_memread && reg_match(ex_rd, id_valid, id_rs, id_rt, id_uses_rt);
  assign mul_haz     = mul_busy && id_valid &&
                       (reg_match(mul_rd_q, id_valid, id_rs, id_rt, id_uses_rt) || id_is_mul);
  assign state       = state_q;
  assign stall_count = stall_cnt_q;

  always_comb begin
    mul_rd_d  = mul_rd_q;
    mul_cnt_d = mul_cnt_q;
    if (mul_start) begin
      mul_cnt_d = MCW'(MUL_LAT);
      mul_rd_d  = mul_rd;
    end else if (mul_cnt_q != '0) begin
      mul_cnt_d = mul_cnt_q - MCW'(1);
    end
  end

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_RUN: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYC > 1) begin
              state_d     = ST_FLUSH;
              flush_cnt_d = FCW'(FLUSH_CYC - 1);
            end
          end else if (load_haz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (mul_haz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (!mul_done) state_d = ST_MUL_WAIT;
          end
        end
        ST_MUL_WAIT: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYC > 1) begin
              state_d     = ST_FLUSH;
              flush_cnt_d = FCW'(FLUSH_CYC - 1);
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (mul_done) state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (branch_taken) begin
            flush_cnt_d = FCW'(FLUSH_CYC - 1);
          end else begin
            flush_cnt_d = flush_cnt_q - FCW'(1);
            if (flush_cnt_q == FCW'(1)) state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      mul_cnt_q   <= '0;
      mul_rd_q    <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      mul_rd_q    <= mul_rd_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with hand-computed expectations
// (MUL_LAT=3, FLUSH_CYC=2, CNT_W=4).
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_rs;
  logic [3:0] id_rt;
  logic       id_uses_rt;
  logic       id_is_mul;
  logic       ex_memread;
  logic [3:0] ex_rd;
  logic       mul_start;
  logic [3:0] mul_rd;
  logic       branch_taken;
  logic       pc_write;
  logic       ifid_write;
  logic       idex_bubble;
  logic       ifid_flush;
  logic       mul_busy;
  logic       mul_done;
  logic [1:0] state;
  logic [3:0] stall_count;

  int total = 0;
  int bad   = 0;

  hazard_stall_ctrl #(
    .REG_AW(4), .MUL_LAT(3), .FLUSH_CYC(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_is_mul(id_is_mul),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mul_start(mul_start), .mul_rd(mul_rd),
    .branch_taken(branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .mul_busy(mul_busy), .mul_done(mul_done),
    .state(state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Issuing a multiply while one is in flight is a protocol error.
  always @(posedge clk) begin
    if (!rst && mul_start && mul_busy) begin
      bad = bad + 1;
      $error("FAIL mul_start_while_busy observed=1 expected=0");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total = total + 1;
    assert (observed === expected)
    else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCtl(input string tag, input logic pw, input logic bub,
                          input logic fl, input logic [1:0] st);
    checkOutput({tag, ".pc_write"}, 32'(pc_write), 32'(pw));
    checkOutput({tag, ".ifid_write"}, 32'(ifid_write), 32'(pw || fl));
    checkOutput({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
    checkOutput({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(fl));
    checkOutput({tag, ".state"}, 32'(state), 32'(st));
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                               input logic urt, input logic ismul, input logic mr,
                               input logic [3:0] erd, input logic ms, input logic [3:0] mrd,
                               input logic br);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_is_mul = ismul;
    ex_memread = mr; ex_rd = erd; mul_start = ms; mul_rd = mrd; branch_taken = br;
    #1;
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCtl("reset", 1, 0, 0, 0);
    checkOutput("reset.stall_count", 32'(stall_count), 0);
    checkOutput("reset.mul_busy", 32'(mul_busy), 0);
    checkOutput("reset.mul_done", 32'(mul_done), 0);
    tick();
    rst = 1'b0;
    #1;
    checkCtl("idle", 1, 0, 0, 0);

    // Load-use: one stall cycle, then forwarding takes over.
    applyStimulus(1, 5, 0, 0, 0, 1, 5, 0, 0, 0);
    checkCtl("load.stall", 0, 1, 0, 0);
    tick();
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCtl("load.after", 1, 0, 0, 0);
    checkOutput("load.stall_count", 32'(stall_count), 1);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkCtl("load.r0", 1, 0, 0, 0);
    applyStimulus(0, 5, 0, 0, 0, 1, 5, 0, 0, 0);
    checkCtl("load.invalid", 1, 0, 0, 0);
    applyStimulus(1, 2, 5, 1, 0, 1, 5, 0, 0, 0);
    checkCtl("load.rt", 0, 1, 0, 0);
    applyStimulus(1, 2, 5, 0, 0, 1, 5, 0, 0, 0);
    checkCtl("load.rt_unused", 1, 0, 0, 0);
    tick();

    // Multiply dependency on rt, starting the cycle after issue.
    applyStimulus(1, 2, 0, 0, 0, 0, 0, 1, 7, 0);
    checkCtl("mul.issue", 1, 0, 0, 0);
    checkOutput("mul.issue.busy", 32'(mul_busy), 0);
    tick();
    applyStimulus(1, 2, 7, 1, 0, 0, 0, 0, 0, 0);
    checkCtl("mul.c1", 0, 1, 0, 0);
    checkOutput("mul.c1.busy", 32'(mul_busy), 1);
    checkOutput("mul.c1.done", 32'(mul_done), 0);
    tick();
    checkCtl("mul.c2", 0, 1, 0, 1);
    checkOutput("mul.c2.done", 32'(mul_done), 0);
    tick();
    checkCtl("mul.c3", 0, 1, 0, 1);
    checkOutput("mul.c3.done", 32'(mul_done), 1);
    tick();
    checkCtl("mul.c4", 1, 0, 0, 0);
    checkOutput("mul.c4.busy", 32'(mul_busy), 0);
    checkOutput("mul.stall_count", 32'(stall_count), 4);

    // Structural multiply hazard resolves in RUN when mul_done is already high.
    applyStimulus(1, 2, 0, 0, 0, 0, 0, 1, 9, 0);
    tick();
    applyStimulus(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    applyStimulus(1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("mulst.done", 32'(mul_done), 1);
    checkCtl("mulst.stall", 0, 1, 0, 0);
    tick();
    checkCtl("mulst.after", 1, 0, 0, 0);

    // Branch beats a simultaneous load hazard; flush lasts two cycles.
    applyStimulus(1, 5, 0, 0, 0, 1, 5, 0, 0, 1);
    checkCtl("br.c1", 1, 1, 1, 0);
    tick();
    applyStimulus(1, 5, 0, 0, 0, 1, 5, 0, 0, 0);
    checkCtl("br.c2", 1, 1, 1, 2);
    tick();
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCtl("br.c3", 1, 0, 0, 0);
    checkOutput("br.stall_count", 32'(stall_count), 5);

    // A second branch during FLUSH extends the flush.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    checkCtl("br2.c2", 1, 1, 1, 2);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCtl("br2.c3", 1, 1, 1, 2);
    tick();
    checkCtl("br2.c4", 1, 0, 0, 0);

    // Branch while waiting on a multiply overrides the stall.
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 1, 3, 0);
    tick();
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkCtl("mbr.wait", 0, 1, 0, 1);
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
    checkCtl("mbr.branch", 1, 1, 1, 1);
    tick();
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCtl("mbr.flush", 1, 1, 1, 2);
    checkOutput("mbr.done", 32'(mul_done), 1);
    tick();
    checkCtl("mbr.run", 1, 0, 0, 0);

    // Reset in the middle of MUL_WAIT.
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 1, 3, 0);
    tick();
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkCtl("rstm.wait", 0, 1, 0, 1);
    rst = 1'b1;
    #1;
    checkCtl("rstm.during", 1, 0, 0, 0);
    checkOutput("rstm.busy", 32'(mul_busy), 0);
    checkOutput("rstm.stall_count", 32'(stall_count), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("rstm.no_done", 32'(mul_done), 0);
      checkOutput("rstm.no_stall", 32'(pc_write), 1);
      tick();
    end

    // Saturation of the 4-bit stall counter.
    applyStimulus(1, 5, 0, 0, 0, 1, 5, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("sat.ten", 32'(stall_count), 10);
    for (int i = 0; i < 11; i++) tick();
    checkOutput("sat.held", 32'(stall_count), 15);
    checkCtl("sat.still_stalling", 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("sat.final", 32'(stall_count), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
